// File: rtl/td4_prog_loader.sv
// Program memory and byte-stream loader for the TD4 CPU.
// Serves combinational instruction fetch and holds the CPU in reset until a full program is loaded.
module td4_prog_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] instr,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic [7:0]        checksum,
    output logic              busy,
    output logic              cpu_n_reset
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_RUN  = 2'd3;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] wr_ptr_d;
    logic [7:0]        checksum_q;
    logic [7:0]        checksum_d;
    logic              ld_done_q;
    logic              cpu_n_reset_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              beat_s;
    logic              last_s;
    logic              ready_s;

    // Running mod-256 checksum; wider data words contribute their low byte.
    function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [DATA_W-1:0] b);
        logic [7:0] b8;
        b8 = 8'(b);
        return acc + b8;
    endfunction

    assign ready_s = (state_q == ST_LOAD);
    assign beat_s  = ld_valid & ready_s;
    assign last_s  = (wr_ptr_q == {ADDR_W{1'b1}});

    // Next-state, write pointer and checksum update.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        checksum_d = checksum_q;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (ld_start) begin
                    state_d    = ST_LOAD;
                    wr_ptr_d   = {ADDR_W{1'b0}};
                    checksum_d = 8'h00;
                end else begin
                    state_d    = state_q;
                end
            end
            ST_LOAD: begin
                if (beat_s) begin
                    wr_ptr_d   = wr_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    checksum_d = sum8(checksum_q, ld_data);
                    if (last_s) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_HOLD: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d    = ST_IDLE;
                wr_ptr_d   = {ADDR_W{1'b0}};
                checksum_d = 8'h00;
            end
        endcase
    end

    // Control registers; outputs to the CPU side are registered from next state.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= {ADDR_W{1'b0}};
            checksum_q    <= 8'h00;
            ld_done_q     <= 1'b0;
            cpu_n_reset_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            checksum_q    <= checksum_d;
            ld_done_q     <= (state_d == ST_HOLD);
            cpu_n_reset_q <= (state_d == ST_RUN);
        end
    end

    // Program storage; a reset discards any partially loaded program.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else if (beat_s) begin
            mem_q[wr_ptr_q] <= ld_data;
        end
    end

    // Fetch path: zero-latency read, NOP (ADD A,0) whenever the CPU is not running.
    always_comb begin
        if (state_q == ST_RUN) begin
            instr = mem_q[address];
        end else begin
            instr = {DATA_W{1'b0}};
        end
    end

    assign ld_ready    = ready_s;
    assign busy        = (state_q == ST_LOAD) | (state_q == ST_HOLD);
    assign ld_done     = ld_done_q;
    assign cpu_n_reset = cpu_n_reset_q;
    assign checksum    = checksum_q;

endmodule

// File: tb/tb_td4_prog_loader.sv
// Self-checking bench for td4_prog_loader: randomized loads against a program-array reference model.
module tb_td4_prog_loader;

    logic       clk = 1'b0;
    logic       n_reset;
    logic [3:0] address;
    logic [7:0] instr;
    logic       ld_start;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic       ld_done;
    logic [7:0] checksum;
    logic       busy;
    logic       cpu_n_reset;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the program the bench is loading, and the memory it expects afterwards.
    logic [7:0] cur_prog [16];

    always #5 clk = ~clk;

    td4_prog_loader #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .address     (address),
        .instr       (instr),
        .ld_start    (ld_start),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .ld_done     (ld_done),
        .checksum    (checksum),
        .busy        (busy),
        .cpu_n_reset (cpu_n_reset)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] psum(input int k);
        logic [7:0] s;
        s = 8'h00;
        for (int j = 0; j < k; j++) s = s + cur_prog[j];
        return s;
    endfunction

    task automatic check_idle_outputs(input string tag);
        address = 4'($urandom);
        #1;
        chk({tag, "_instr"}, instr, 0);
        chk({tag, "_cpu"}, cpu_n_reset, 0);
        chk({tag, "_ready"}, ld_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, ld_done, 0);
        chk({tag, "_sum"}, checksum, 0);
    endtask

    task automatic read_all(input string tag);
        logic [3:0] r;
        logic [3:0] a;
        r = 4'($urandom);
        for (int k = 0; k < 16; k++) begin
            a = 4'(k) ^ r;
            address = a;
            #1;
            chk({tag, "_instr"}, instr, cur_prog[a]);
        end
    endtask

    // Full 16-byte load of cur_prog with random idle gaps; optionally stray ld_start pulses.
    task automatic do_load(input int gap_pct, input bit start_noise);
        ld_valid = 1'b0;
        ld_start = 1'b1;
        address  = 4'($urandom);
        step();
        ld_start = 1'b0;
        chk("start_ready", ld_ready, 1);
        chk("start_busy", busy, 1);
        chk("start_cpu", cpu_n_reset, 0);
        chk("start_sum", checksum, 0);
        for (int i = 0; i < 16; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                ld_valid = 1'b0;
                ld_data  = 8'($urandom);
                ld_start = start_noise ? 1'($urandom_range(1)) : 1'b0;
                address  = 4'($urandom);
                step();
                chk("gap_ready", ld_ready, 1);
                chk("gap_sum", checksum, psum(i));
                chk("gap_instr", instr, 0);
                chk("gap_cpu", cpu_n_reset, 0);
            end
            ld_valid = 1'b1;
            ld_data  = cur_prog[i];
            ld_start = start_noise ? 1'($urandom_range(1)) : 1'b0;
            step();
            if (i < 15) begin
                chk("beat_ready", ld_ready, 1);
                chk("beat_sum", checksum, psum(i + 1));
                chk("beat_done", ld_done, 0);
            end
        end
        ld_valid = 1'b0;
        ld_start = 1'b0;
        chk("hold_done", ld_done, 1);
        chk("hold_ready", ld_ready, 0);
        chk("hold_busy", busy, 1);
        chk("hold_cpu", cpu_n_reset, 0);
        chk("hold_sum", checksum, psum(16));
        step();
        chk("run_done", ld_done, 0);
        chk("run_cpu", cpu_n_reset, 1);
        chk("run_busy", busy, 0);
        chk("run_ready", ld_ready, 0);
        chk("run_sum", checksum, psum(16));
        read_all("run");
    endtask

    initial begin
        logic [7:0] test_prog [9];
        test_prog = '{8'h30, 8'h40, 8'h90, 8'h01, 8'hE1, 8'h40, 8'h90, 8'h00, 8'hF7};
        n_reset  = 1'b0;
        address  = 4'h0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data  = 8'h00;
        step();
        step();
        n_reset = 1'b1;
        step();
        check_idle_outputs("reset");

        // Offered bytes in IDLE are not consumed.
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_data  = 8'($urandom);
            step();
            check_idle_outputs("idle_valid");
        end
        ld_valid = 1'b0;

        // CPU test program.
        for (int i = 0; i < 16; i++) cur_prog[i] = (i < 9) ? test_prog[i] : 8'h00;
        do_load(0, 1'b0);
        step();
        step();
        chk("run_stay_cpu", cpu_n_reset, 1);
        read_all("run_stay");

        // Bytes 1..16 with gaps and stray starts.
        for (int i = 0; i < 16; i++) cur_prog[i] = 8'(i + 1);
        do_load(50, 1'b1);
        chk("seq_sum88", checksum, psum(16));

        // All 0xFF.
        for (int i = 0; i < 16; i++) cur_prog[i] = 8'hFF;
        do_load(0, 1'b0);

        // Reset after 7 beats of a partial load.
        for (int i = 0; i < 16; i++) cur_prog[i] = 8'($urandom);
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            ld_valid = 1'b1;
            ld_data  = cur_prog[i];
            step();
        end
        chk("partial_sum", checksum, psum(7));
        ld_valid = 1'b0;
        n_reset  = 1'b0;
        step();
        n_reset = 1'b1;
        check_idle_outputs("midreset");
        step();
        check_idle_outputs("midreset2");

        // Fresh loads restart at address 0.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) cur_prog[i] = 8'($urandom);
            do_load(30, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
